// File: rtl/adder_64_pkg.sv
// Shared types and constants for the adder_64 operand-issue slice.
package adder_64_pkg;

  localparam int DATA_W    = 64;
  localparam int TAG_W_DEF = 8;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
  } operand_t;

  localparam int OPERAND_W = $bits(operand_t);

endpackage

// File: rtl/adder_64_op_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO; no full bypass, no empty bypass.
module adder_64_op_fifo
  import adder_64_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = OPERAND_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/adder_64_op_issue.sv
// Operand-issue stage for adder_64: FIFO, issue register, tag counter, result-alignment pipe.
// Optional counters stat_issued/stat_full exist only when ADDER64_ISSUE_STATS_EN is defined.
module adder_64_op_issue
  import adder_64_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDER_LAT = 1,
  parameter int TAG_W     = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_cin,
  input  logic              hold,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              cin_out,
  output logic              issue_valid,
  output logic [TAG_W-1:0]  issue_tag,
  output logic              res_valid,
  output logic [TAG_W-1:0]  res_tag
`ifdef ADDER64_ISSUE_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_full
`endif
);

  operand_t                 wr_op;
  operand_t                 rd_op;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [$clog2(DEPTH):0]   fifo_count_unused;
  logic                     push;
  logic                     pop;
  logic [TAG_W-1:0]         next_tag;
  logic [ADDER_LAT-1:0]     vld_pipe;
  logic [TAG_W-1:0]         tag_pipe [ADDER_LAT];

  assign wr_op    = '{a: in_a, b: in_b, cin: in_cin};
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = !hold && !fifo_empty;

  adder_64_op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OPERAND_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_op),
    .rdata (rd_op),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

  // Adder inputs hold their last value between issues so the adder sees stable operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out       <= '0;
      b_out       <= '0;
      cin_out     <= 1'b0;
      issue_valid <= 1'b0;
      issue_tag   <= '0;
      next_tag    <= '0;
    end else begin
      issue_valid <= pop;
      if (pop) begin
        a_out     <= rd_op.a;
        b_out     <= rd_op.b;
        cin_out   <= rd_op.cin;
        issue_tag <= next_tag;
        next_tag  <= next_tag + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < ADDER_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= issue_valid;
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < ADDER_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign res_valid = vld_pipe[ADDER_LAT-1];
  assign res_tag   = tag_pipe[ADDER_LAT-1];

`ifdef ADDER64_ISSUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued <= '0;
      stat_full   <= '0;
    end else begin
      if (issue_valid && (stat_issued != '1)) stat_issued <= stat_issued + 1'b1;
      if (in_valid && !in_ready && (stat_full != '1)) stat_full <= stat_full + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_64_op_issue.sv
// Self-checking bench for adder_64_op_issue with a behavioural adder_64 and a tag scoreboard.
module tb_adder_64_op_issue;
  import adder_64_pkg::*;

  localparam int DEPTH     = 4;
  localparam int ADDER_LAT = 1;
  localparam int TAG_W     = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_a;
  logic [63:0]       in_b;
  logic              in_cin;
  logic              hold;
  logic [63:0]       a_out;
  logic [63:0]       b_out;
  logic              cin_out;
  logic              issue_valid;
  logic [TAG_W-1:0]  issue_tag;
  logic              res_valid;
  logic [TAG_W-1:0]  res_tag;
`ifdef ADDER64_ISSUE_STATS_EN
  logic [31:0]       stat_issued;
  logic [31:0]       stat_full;
`endif

  adder_64_op_issue #(.DEPTH(DEPTH), .ADDER_LAT(ADDER_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .hold(hold),
    .a_out(a_out), .b_out(b_out), .cin_out(cin_out),
    .issue_valid(issue_valid), .issue_tag(issue_tag),
    .res_valid(res_valid), .res_tag(res_tag)
`ifdef ADDER64_ISSUE_STATS_EN
    , .stat_issued(stat_issued), .stat_full(stat_full)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural adder_64 with one register stage.
  logic [63:0] add_sum;
  logic        add_cout;
  always @(posedge clk) {add_cout, add_sum} <= {1'b0, a_out} + {1'b0, b_out} + 65'(cin_out);

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [63:0]      a;
    logic [63:0]      b;
    logic             cin;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
  } vec_t;

  exp_t             iss_q[$];
  exp_t             res_q[$];
  exp_t             e_iss;
  exp_t             e_res;
  logic [TAG_W-1:0] exp_tag;
  logic [TAG_W-1:0] last_tag;
  logic [64:0]      exp_full_sum;
  int               n_pass = 0;
  int               n_total = 0;
  int               cyc = 0;
  int               bench_full = 0;
  int               bench_issued = 0;
  int               last_iss_cyc = 0;
  int               first_stream_cyc = -1;
  bit               stream_on = 0;
  bit               wrap_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      iss_q.delete();
      res_q.delete();
      exp_tag      = '0;
      bench_full   = 0;
      bench_issued = 0;
    end else begin
      if (issue_valid) begin
        bench_issued++;
        if (issue_tag == '0 && last_tag == '1) wrap_seen = 1;
        last_tag     = issue_tag;
        last_iss_cyc = cyc;
        if (stream_on && first_stream_cyc < 0) first_stream_cyc = cyc;
        if (iss_q.size() == 0) check("issue_unexpected", 1, 0);
        else begin
          e_iss = iss_q.pop_front();
          check("sb_issue_tag", issue_tag, e_iss.tag);
          check("sb_a_out", a_out, e_iss.a);
          check("sb_b_out", b_out, e_iss.b);
          check("sb_cin_out", cin_out, e_iss.cin);
          res_q.push_back(e_iss);
        end
      end
      if (res_valid) begin
        if (res_q.size() == 0) check("res_unexpected", 1, 0);
        else begin
          e_res = res_q.pop_front();
          exp_full_sum = {1'b0, e_res.a} + {1'b0, e_res.b} + 65'(e_res.cin);
          check("sb_res_tag", res_tag, e_res.tag);
          check("sb_res_sum", {add_cout, add_sum}, exp_full_sum);
        end
      end
      if (in_valid && in_ready) begin
        iss_q.push_back('{exp_tag, in_a, in_b, in_cin});
        exp_tag++;
      end
      if (in_valid && !in_ready) bench_full++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t             vecs[4];
    int               n;
    int               sent;
    int               guard;
    int               stream_mark;
    bit               acc;
    logic [TAG_W-1:0] prev_tag;

    vecs[0] = '{64'h0000_FF00_FFFF_00FF, 64'h0000_00FF_0000_FF00, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'h1, 1'b1};
    vecs[3] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 64'h2345_6789_ABCD_F001, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_issue_valid", issue_valid, 0);
    check("rst_a_out", a_out, 0);
    check("rst_issue_tag", issue_tag, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_tag", res_tag, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    prev_tag = '0;
    for (int i = 0; i < 4; i++) begin
      in_a = vecs[i].a; in_b = vecs[i].b; in_cin = vecs[i].cin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!issue_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check("vec_issue_latency", n, 2);
      if (i == 0) check("vec_first_tag", issue_tag, 0);
      else check("vec_tag_step", issue_tag, prev_tag + 1'b1);
      prev_tag = issue_tag;
      @(posedge clk); #1;
      check("vec_res_valid", res_valid, 1);
      check("vec_res_tag", res_tag, prev_tag);
      check("vec_sum", add_sum, vecs[i].sum);
      check("vec_cout", add_cout, vecs[i].cout);
      @(posedge clk); #1;
    end

    // Reset with three triples buffered behind hold.
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_cin = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst_a_out", a_out, 0);
    check("mrst_b_out", b_out, 0);
    check("mrst_cin_out", cin_out, 0);
    check("mrst_issue_tag", issue_tag, 0);
    check("mrst_res_tag", res_tag, 0);
    check("mrst_res_valid", res_valid, 0);
    check("mrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0; hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("mrst_no_issue", issue_valid, 0);
      check("mrst_no_res", res_valid, 0);
    end

    // Back-pressure: four fill the FIFO, the fifth waits at the source.
    hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_cin = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    check("bp_full_ready", in_ready, 0);
    in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_cin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_held_ready", in_ready, 0);
    check("bp_held_issue", issue_valid, 0);
    hold = 1'b0;
    @(posedge clk); #1;
    check("bp_first_issue", issue_valid, 1);
    check("bp_first_tag", issue_tag, 0);
    check("bp_ready_rise", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_issue_2", issue_valid, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("bp_issue_run", issue_valid, 1);
    end
    @(posedge clk); #1;
    check("bp_drained", issue_valid, 0);
    check("bp_issued_count", bench_issued, 5);
`ifdef ADDER64_ISSUE_STATS_EN
    check("stat_issued", stat_issued, 5);
    check("stat_full", stat_full, bench_full);
`endif
    @(posedge clk); #1;

    // Streaming 300 triples with hold low.
    stream_mark = bench_issued;
    stream_on   = 1;
    sent = 0; guard = 0;
    in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_cin = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    while (sent < 300 && guard < 2000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        sent++;
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_cin = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0;
    check("stream_sent", sent, 300);
    repeat (5) @(posedge clk);
    #1;
    check("stream_issued", bench_issued - stream_mark, 300);
    check("stream_one_per_clk", last_iss_cyc - first_stream_cyc + 1, 300);
    check("stream_tag_wrap", wrap_seen, 1);
    check("final_iss_q_empty", iss_q.size(), 0);
    check("final_res_q_empty", res_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adder_64_op_issue.md
Name: adder_64_op_issue

Overview:
- Upstream operand-issue stage for adder_64.
- Accepts operand triples {a, b, carry} over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one triple per clock onto the adder_64 inputs (a_in, b_in, carry_in).
- Emits a res_valid/res_tag pulse aligned with the cycle in which adder_64's sum_out/carry_out holds that triple's result, so the downstream consumer can sample the adder without its own timing knowledge.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- ADDER_LAT, 1: clocks from a_out/b_out/cin_out change to valid sum_out; minimum 1.
- TAG_W, 8: width of the issue sequence tag.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand triple offered
- in_ready  output  1  block can accept a triple this cycle
- in_a  input  64  operand A
- in_b  input  64  operand B
- in_cin  input  1  carry in
- hold  input  1  downstream back-pressure; suppresses issue
- a_out  output  64  drives adder_64 a_in
- b_out  output  64  drives adder_64 b_in
- cin_out  output  1  drives adder_64 carry_in
- issue_valid  output  1  a_out/b_out/cin_out carry a new triple this cycle
- issue_tag  output  TAG_W  sequence number of the issued triple
- res_valid  output  1  adder_64 output holds result of triple res_tag
- res_tag  output  TAG_W  tag aligned with res_valid

Behaviour:
Reset (asynchronous, rst=1):
- FIFO empty; write/read pointers and count = 0.
- a_out=0, b_out=0, cin_out=0, issue_valid=0, issue_tag=0.
- res_valid=0, res_tag=0; latency shift register cleared.
- Reset mid-operation discards all buffered and in-flight triples; no res_valid is produced for them.

Accept:
- Push when in_valid & in_ready. in_ready = (count != DEPTH), registered-state based with no combinational dependence on in_valid or hold.
- When the FIFO is full, in_ready=0 even if a pop occurs that cycle (no full-bypass).

Issue:
- Pop when !hold & count != 0. On the next clock edge: a_out/b_out/cin_out take the popped entry, issue_valid=1, issue_tag increments by 1.
- issue_tag is 0 for the first issued triple after reset and wraps modulo 2^TAG_W.
- No pop in a cycle → issue_valid=0 next cycle; a_out/b_out/cin_out hold their last value (adder input stays stable); issue_tag holds.
- Issue rate: one triple per clock max; FIFO to adder latency is 1 clock after the entry is at the FIFO head.

Simultaneous events and pointers:
- Push and pop in the same cycle leave count unchanged. Both pointers wrap at DEPTH.
- Push into an empty FIFO: the entry is not issued in the same cycle. It is poppable the following cycle, so issue_valid asserts 2 clocks after the accepting edge.
- hold asserted: no pop; FIFO keeps accepting until full.

Result alignment:
- res_valid/res_tag = issue_valid/issue_tag delayed by ADDER_LAT clocks via a shift register.

Optional Feature:
- Macro ADDER64_ISSUE_STATS_EN.
- Defined: adds outputs stat_issued (32 bits, count of issue_valid cycles) and stat_full (32 bits, count of cycles with in_valid & !in_ready). Both saturate at all-ones and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package adder_64_pkg holds DATA_W=64, the operand-triple struct/width constant (129 bits), and the default TAG_W.
- Sub-module adder_64_op_fifo: generic DEPTH x WIDTH synchronous FIFO with push, pop, full, empty and count. The top holds the issue register, tag counter, latency pipe and stats.

Test Plan:
- Reset: assert rst mid-stream with 3 triples buffered → all outputs 0 immediately; after release, res_valid stays 0 and the first new issue carries issue_tag=0.
- Single op: push a=64'h0000_FF00_FFFF_00FF, b=64'h0000_00FF_0000_FF00, cin=0 with hold=0 → issue_valid at accepting edge+2; res_valid at ADDER_LAT later with adder sum 64'h0000_FFFF_FFFF_FFFF.
- Overflow case: push a=all-ones, b=0, cin=1 → res_valid aligns with adder carry_out=1, sum_out=0; tag increments by 1 from the previous op.
- Back-pressure: hold=1 and push 5 triples with DEPTH=4 → in_ready falls after the 4th, and the 5th is held by the source. Release hold → 4 consecutive issue_valid cycles in FIFO order, in_ready rises one cycle after the first pop, and the 5th issues next.
- Streaming: continuous in_valid for 300 triples with hold=0 → one issue per clock in steady state; issue_tag wraps 255→0; res_tag sequence matches issue_tag delayed by ADDER_LAT.
- ADDER64_ISSUE_STATS_EN build: back-pressure scenario → stat_full equals the in_valid & !in_ready cycles counted by the bench, and stat_issued=5 after drain.
